// File: rtl/factor_judge_if.sv
// factor_judge_if
//   Bundles the game-FSM/digit-entry side signals and the judge outputs.
//   master : game side (drives state, dec, question, digits; observes results)
//   slave  : factor_judge (observes inputs; drives result, result_vld, busy,
//            miss_cnt, lose_req, product)
interface factor_judge_if;
    logic [3:0]  state;
    logic        dec;
    logic [23:0] question;
    logic [3:0]  count1_out;
    logic [3:0]  count2_out;
    logic [3:0]  count3_out;
    logic [1:0]  result;
    logic        result_vld;
    logic        busy;
    logic [2:0]  miss_cnt;
    logic        lose_req;
    logic [9:0]  product;

    modport master (
        output state, dec, question, count1_out, count2_out, count3_out,
        input  result, result_vld, busy, miss_cnt, lose_req, product
    );

    modport slave (
        input  state, dec, question, count1_out, count2_out, count3_out,
        output result, result_vld, busy, miss_cnt, lose_req, product
    );
endinterface

// File: rtl/factor_judge.sv
// factor_judge
//   Judge stage of the factorization game. On a rising edge of dec while the
//   game is in INPUT, multiplies the three entered digits and compares the
//   product with the BCD question, reports CORRECT/WRONG, counts misses and
//   raises lose_req once the miss count reaches MAX_MISS.
// Ports
//   clk  : system clock, rising edge
//   rst  : synchronous reset, active-low
//   bus  : factor_judge_if.slave (state, dec, question, count1..3_out in;
//          result, result_vld, busy, miss_cnt, lose_req, product out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a dec rising edge in INPUT
// LOAD   | capture digits and question nibbles
// CONV   | BCD question to binary, flag invalid nibbles
// MUL1   | p1 = d1 * d2
// MUL2   | p  = p1 * d3
// CMP    | compare and update result / miss count (always completes)
module factor_judge #(
    parameter int         MAX_MISS = 3,
    parameter logic [3:0] ST_READY = 4'b0010,
    parameter logic [3:0] ST_INPUT = 4'b0100
) (
    input  logic           clk,
    input  logic           rst,
    factor_judge_if.slave  bus
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_CONV = 3'd2;
    localparam logic [2:0] S_MUL1 = 3'd3;
    localparam logic [2:0] S_MUL2 = 3'd4;
    localparam logic [2:0] S_CMP  = 3'd5;

    localparam logic [2:0] MAX_MISS_C = 3'(MAX_MISS);

    logic [2:0] fsm;
    logic [2:0] fsm_nxt;
    logic       dec_d;

    logic [3:0] d1, d2, d3;
    logic [3:0] qh, qt, qo;
    logic       any_nz;
    logic       q_bad;
    logic [9:0] q_bin;
    logic [6:0] p1;
    logic [9:0] p;

    logic [1:0] result_r;
    logic       result_vld_r;
    logic       busy_r;
    logic [2:0] miss_r;
    logic       lose_r;
    logic [9:0] product_r;

    logic       in_input;
    logic       in_ready;
    logic       req;
    logic       match;
    logic [2:0] miss_inc;
    logic       unused_question_low;

    // Only the upper 12 bits carry the question; the low half belongs to
    // other consumers of the same bus.
    assign unused_question_low = ^bus.question[11:0];

    assign in_input = (bus.state == ST_INPUT);
    assign in_ready = (bus.state == ST_READY);
    assign req      = bus.dec & ~dec_d & in_input &
                      (bus.question[23:12] != 12'h000) & (fsm == S_IDLE);

    // Invalid BCD can alias to a legal binary value, so it vetoes the match.
    assign match    = (p == q_bin) & any_nz & ~q_bad;
    assign miss_inc = (miss_r >= MAX_MISS_C) ? MAX_MISS_C : miss_r + 3'd1;

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            S_IDLE: if (req) fsm_nxt = S_LOAD;
            S_LOAD: fsm_nxt = in_input ? S_CONV : S_IDLE;
            S_CONV: fsm_nxt = in_input ? S_MUL1 : S_IDLE;
            S_MUL1: fsm_nxt = in_input ? S_MUL2 : S_IDLE;
            S_MUL2: fsm_nxt = in_input ? S_CMP  : S_IDLE;
            S_CMP:  fsm_nxt = S_IDLE;
            default: fsm_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fsm    <= S_IDLE;
            busy_r <= 1'b0;
            dec_d  <= 1'b0;
        end else begin
            fsm    <= fsm_nxt;
            busy_r <= (fsm_nxt != S_IDLE);
            dec_d  <= bus.dec;
        end
    end

    // Datapath; a zero digit is an unused slot and multiplies as 1.
    always_ff @(posedge clk) begin
        if (!rst) begin
            d1     <= 4'd1;
            d2     <= 4'd1;
            d3     <= 4'd1;
            qh     <= 4'd0;
            qt     <= 4'd0;
            qo     <= 4'd0;
            any_nz <= 1'b0;
            q_bad  <= 1'b0;
            q_bin  <= 10'd0;
            p1     <= 7'd0;
            p      <= 10'd0;
        end else begin
            case (fsm)
                S_LOAD: begin
                    d1     <= (bus.count1_out == 4'd0) ? 4'd1 : bus.count1_out;
                    d2     <= (bus.count2_out == 4'd0) ? 4'd1 : bus.count2_out;
                    d3     <= (bus.count3_out == 4'd0) ? 4'd1 : bus.count3_out;
                    any_nz <= |{bus.count1_out, bus.count2_out, bus.count3_out};
                    qh     <= bus.question[23:20];
                    qt     <= bus.question[19:16];
                    qo     <= bus.question[15:12];
                end
                S_CONV: begin
                    q_bin <= ({6'd0, qh} * 10'd100) + ({6'd0, qt} * 10'd10) + {6'd0, qo};
                    q_bad <= (qh > 4'd9) | (qt > 4'd9) | (qo > 4'd9);
                end
                S_MUL1: p1 <= {3'd0, d1} * {3'd0, d2};
                S_MUL2: p  <= {3'd0, p1} * {6'd0, d3};
                default: ;
            endcase
        end
    end

    // A READY clear in the same cycle as CMP wins; the comparison is lost.
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_r     <= 2'b00;
            result_vld_r <= 1'b0;
            miss_r       <= 3'd0;
            lose_r       <= 1'b0;
            product_r    <= 10'd0;
        end else begin
            result_vld_r <= 1'b0;
            if (in_ready) begin
                result_r  <= 2'b00;
                miss_r    <= 3'd0;
                lose_r    <= 1'b0;
                product_r <= 10'd0;
            end else if (fsm == S_CMP) begin
                result_vld_r <= 1'b1;
                product_r    <= p;
                if (match) begin
                    result_r <= 2'b01;
                end else begin
                    result_r <= 2'b10;
                    miss_r   <= miss_inc;
                    lose_r   <= (miss_inc == MAX_MISS_C);
                end
            end
        end
    end

    assign bus.result     = result_r;
    assign bus.result_vld = result_vld_r;
    assign bus.busy       = busy_r;
    assign bus.miss_cnt   = miss_r;
    assign bus.lose_req   = lose_r;
    assign bus.product    = product_r;

endmodule

// File: tb/tb_factor_judge.sv
// tb_factor_judge
//   Scoreboard bench for factor_judge: each accepted press pushes the
//   expected outcome from a small reference model; a monitor pops and
//   compares whenever result_vld pulses.
module tb_factor_judge;

    localparam logic [3:0] ST_READY = 4'b0010;
    localparam logic [3:0] ST_INPUT = 4'b0100;
    localparam int         MAX_MISS = 3;

    typedef struct {
        int res;
        int prod;
        int miss;
        int lose;
        int cyc;
    } exp_t;

    logic clk;
    logic rst;
    factor_judge_if bus();

    factor_judge #(
        .MAX_MISS (MAX_MISS),
        .ST_READY (ST_READY),
        .ST_INPUT (ST_INPUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc_cnt = 0;
    int   vld_cnt = 0;
    int   model_miss = 0;
    exp_t sb[$];

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end
    endtask

    // Reference model: zero digit -> factor 1, invalid BCD -> WRONG.
    task automatic push_exp(input logic [11:0] q, input logic [3:0] a,
                            input logic [3:0] b, input logic [3:0] c);
        exp_t e;
        int f1, f2, f3, qv;
        bit bad, ok;
        f1 = (a == 0) ? 1 : int'(a);
        f2 = (b == 0) ? 1 : int'(b);
        f3 = (c == 0) ? 1 : int'(c);
        qv = int'(q[11:8]) * 100 + int'(q[7:4]) * 10 + int'(q[3:0]);
        bad = (q[11:8] > 9) || (q[7:4] > 9) || (q[3:0] > 9);
        ok = !bad && (f1 * f2 * f3 == qv) && ({a, b, c} != 12'h000);
        if (!ok && model_miss < MAX_MISS) model_miss++;
        e.res  = ok ? 1 : 2;
        e.prod = f1 * f2 * f3;
        e.miss = model_miss;
        e.lose = (model_miss == MAX_MISS) ? 1 : 0;
        e.cyc  = cyc_cnt;
        sb.push_back(e);
    endtask

    task automatic set_inputs(input logic [11:0] q, input logic [3:0] a,
                              input logic [3:0] b, input logic [3:0] c);
        bus.question   = {q, 12'h000};
        bus.count1_out = a;
        bus.count2_out = b;
        bus.count3_out = c;
    endtask

    task automatic press(input logic [11:0] q, input logic [3:0] a,
                         input logic [3:0] b, input logic [3:0] c,
                         input int hold, input bit expect_out);
        @(posedge clk); #1;
        set_inputs(q, a, b, c);
        bus.dec = 1'b1;
        if (expect_out) push_exp(q, a, b, c);
        repeat (hold) @(posedge clk);
        #1 bus.dec = 1'b0;
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_result"}, int'(bus.result), 0);
        chk({tag, "_vld"},    int'(bus.result_vld), 0);
        chk({tag, "_busy"},   int'(bus.busy), 0);
        chk({tag, "_miss"},   int'(bus.miss_cnt), 0);
        chk({tag, "_lose"},   int'(bus.lose_req), 0);
        chk({tag, "_prod"},   int'(bus.product), 0);
    endtask

    always @(negedge clk) begin
        if (bus.result_vld === 1'b1) begin
            vld_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_vld", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("result",   int'(bus.result),   e.res);
                chk("product",  int'(bus.product),  e.prod);
                chk("miss_cnt", int'(bus.miss_cnt), e.miss);
                chk("lose_req", int'(bus.lose_req), e.lose);
                chk("latency",  cyc_cnt - e.cyc,    6);
            end
        end
    end

    initial begin
        int v0;
        rst = 1'b0;
        bus.state = ST_INPUT;
        bus.dec = 1'b0;
        set_inputs(12'h000, 4'd0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1 chk_all_zero("reset");
        rst = 1'b1;

        press(12'h105, 4'd3, 4'd5, 4'd7, 1, 1'b1);
        press(12'h012, 4'd2, 4'd2, 4'd0, 1, 1'b1);
        press(12'h012, 4'd2, 4'd2, 4'd0, 1, 1'b1);
        press(12'h012, 4'd2, 4'd2, 4'd0, 1, 1'b1);
        press(12'h012, 4'd2, 4'd2, 4'd0, 1, 1'b1);

        // READY clears miss count, lose request, result and product.
        @(posedge clk); #1 bus.state = ST_READY;
        @(posedge clk); #1;
        chk_all_zero("ready");
        bus.state = ST_INPUT;
        model_miss = 0;

        press(12'h007, 4'd0, 4'd0, 4'd7, 1, 1'b1);
        press(12'h007, 4'd0, 4'd0, 4'd0, 1, 1'b1);
        // Invalid tens nibble aliases to 100 in binary; must still be WRONG.
        press(12'h0A0, 4'd4, 4'd5, 4'd5, 1, 1'b1);
        press(12'h729, 4'd9, 4'd9, 4'd9, 1, 1'b1);

        // Zero question: request ignored.
        v0 = vld_cnt;
        press(12'h000, 4'd1, 4'd1, 4'd1, 1, 1'b0);
        chk("zero_q_no_vld", vld_cnt - v0, 0);

        // Held dec gives a single request.
        v0 = vld_cnt;
        press(12'h024, 4'd2, 4'd3, 4'd4, 20, 1'b1);
        chk("held_one_vld", vld_cnt - v0, 1);

        // Second edge while busy is dropped.
        v0 = vld_cnt;
        @(posedge clk); #1;
        set_inputs(12'h018, 4'd2, 4'd3, 4'd3);
        bus.dec = 1'b1;
        push_exp(12'h018, 4'd2, 4'd3, 4'd3);
        @(posedge clk); #1 bus.dec = 1'b0;
        @(posedge clk); #1 bus.dec = 1'b1;
        @(posedge clk); #1 bus.dec = 1'b0;
        repeat (10) @(posedge clk);
        #1 chk("busy_edge_one_vld", vld_cnt - v0, 1);

        // Abort in MUL1.
        v0 = vld_cnt;
        @(posedge clk); #1;
        set_inputs(12'h012, 4'd2, 4'd2, 4'd0);
        bus.dec = 1'b1;
        @(posedge clk); #1 bus.dec = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("abort_busy_mul1", int'(bus.busy), 1);
        bus.state = 4'b0111;
        @(posedge clk); #1;
        chk("abort_busy_low", int'(bus.busy), 0);
        bus.state = ST_INPUT;
        repeat (8) @(posedge clk);
        #1 chk("abort_no_vld", vld_cnt - v0, 0);
        chk("abort_miss", int'(bus.miss_cnt), model_miss);

        // Reset in MUL2 after a miss.
        @(posedge clk); #1;
        set_inputs(12'h012, 4'd2, 4'd2, 4'd0);
        bus.dec = 1'b1;
        repeat (4) @(posedge clk);
        #1 chk("rst_busy_mul2", int'(bus.busy), 1);
        rst = 1'b0;
        bus.dec = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("rst_mul2");
        rst = 1'b1;
        model_miss = 0;
        repeat (8) @(posedge clk);
        #1 chk("rst_no_vld", int'(bus.result_vld), 0);

        press(12'h012, 4'd3, 4'd4, 4'd0, 1, 1'b1);

        chk("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
